one_hot_encoder_stream: RTL
===========================

ONE_HOT_ENCODER_STREAM -- requirements
Module: one_hot_encoder_stream

Interface
REQ-001 SHALL have parameter VALUES, default 8, number of one-hot output lines (legal range 1..1024).
REQ-002 SHALL have parameter BIN_W, default max($clog2(VALUES),1), binary index width (derived; not overridden).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream index beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port in_binary  input  BIN_W  binary index to encode.
REQ-008 SHALL have port out_valid  output  1  encoded beat valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port out_oneHot  output  VALUES  one-hot vector for the head beat.
REQ-011 SHALL have port out_error  output  1  head beat index was out of range.
REQ-012 SHALL have port clear_errors  input  1  synchronous clear of error_count.
REQ-013 SHALL have port error_count  output  8  saturating count of out-of-range beats accepted.

Function
REQ-014 SHALL accept an input beat on a cycle where in_valid and in_ready are both 1; output beat transfers when out_valid and out_ready are both 1.
REQ-015 SHALL encode an accepted index i < VALUES as out_oneHot with exactly bit i set, out_error 0.
REQ-016 SHALL encode an index i >= VALUES (possible when VALUES not a power of two) as out_oneHot all zeros, out_error 1.
REQ-017 SHALL buffer beats in a 2-entry FIFO (output register plus skid register) storing encoded vector and error bit; beats leave in acceptance order, none dropped or duplicated.
REQ-018 SHALL have latency exactly 1 cycle: beat accepted at edge N is presented with out_valid=1 after edge N when the buffer was empty.
REQ-019 SHALL sustain one beat per cycle when out_ready is held 1.
REQ-020 SHALL drive in_ready from a register only: in_ready = 1 iff fewer than 2 entries held after the current edge; no combinational path from out_ready or in_valid to in_ready.
REQ-021 SHALL track occupancy states EMPTY(0), ONE(1), FULL(2): EMPTY->ONE on accept; ONE->ONE on accept+transfer; ONE->FULL on accept without transfer; ONE->EMPTY on transfer without accept; FULL->ONE on transfer (no accept possible in FULL).
REQ-022 SHALL on transfer from FULL move skid entry into output register in the same edge.
REQ-023 SHALL hold out_oneHot and out_error stable while out_valid=1 and out_ready=0.
REQ-024 SHALL increment error_count by 1 on each accepted out-of-range beat (at acceptance, not at output), saturating at 255.
REQ-025 SHALL, when clear_errors=1, set error_count to 0 on that edge; clear takes precedence over a simultaneous increment (result 0).
REQ-026 SHALL leave out_oneHot and out_error don't-care-free: both 0 when out_valid=0.
REQ-027 SHALL for VALUES=1 treat index 0 as valid and index 1 as out of range.

Reset
REQ-028 SHALL on reset_n=0 immediately (asynchronously) set state EMPTY, out_valid 0, in_ready 0, out_oneHot 0, out_error 0, error_count 0.
REQ-029 SHALL drive in_ready 1 on the first clk edge after reset_n deasserts; beats in flight at reset assertion are discarded.

Verification
REQ-030 Reset then in_binary=5 valid one cycle, out_ready=1 -> next cycle out_valid=1, out_oneHot=8'b0010_0000, out_error=0; following cycle out_valid=0.
REQ-031 VALUES=6, in_binary=3'd7 accepted -> out_oneHot=6'b0, out_error=1, error_count=1.
REQ-032 out_ready=0, push indices 1,2 -> in_ready=0 after second accept; raise out_ready -> outputs 8'h02 then 8'h04 on consecutive cycles, in_ready returns 1.
REQ-033 Back-to-back indices 0..7 with out_ready=1 -> 8 consecutive output beats 8'h01..8'h80, no bubbles, in_ready constantly 1.
REQ-034 260 out-of-range beats -> error_count=255; clear_errors with simultaneous bad beat -> error_count=0.
REQ-035 Assert reset_n low mid-stream with FULL buffer -> out_valid, in_ready, error_count 0 without clock edge; after release, first new beat emerges alone.

Source files
------------

// File: rtl/one_hot_encoder_stream.sv
// Streaming binary-to-one-hot encoder with a 2-entry output/skid buffer,
// registered in_ready and a saturating count of out-of-range beats.
module one_hot_encoder_stream #(
  parameter int VALUES = 8,
  parameter int BIN_W  = (VALUES > 1) ? $clog2(VALUES) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIN_W-1:0]  in_binary,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VALUES-1:0] out_oneHot,
  output logic              out_error,
  input  logic              clear_errors,
  output logic [7:0]        error_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [VALUES-1:0] enc_hot;
  logic              enc_err;
  logic [VALUES-1:0] out_hot_reg, out_hot_next;
  logic [VALUES-1:0] skid_hot_reg, skid_hot_next;
  logic              out_err_reg, out_err_next;
  logic              skid_err_reg, skid_err_next;
  logic              in_ready_reg, in_ready_next;
  logic [7:0]        err_cnt_reg, err_cnt_next;
  logic              accept;
  logic              transfer;

  genvar gi;
  generate
    for (gi = 0; gi < VALUES; gi++) begin : g_dec
      assign enc_hot[gi] = (in_binary == BIN_W'(gi));
    end
  endgenerate

  // Out-of-range indices match no decoder bit, so the vector is already zero.
  assign enc_err  = (32'(in_binary) >= 32'(VALUES));

  assign out_valid   = (state_reg != EMPTY);
  assign accept      = in_valid & in_ready_reg;
  assign transfer    = out_valid & out_ready;
  assign in_ready    = in_ready_reg;
  assign out_oneHot  = out_hot_reg;
  assign out_error   = out_err_reg;
  assign error_count = err_cnt_reg;

  always_comb begin
    state_next    = state_reg;
    out_hot_next  = out_hot_reg;
    out_err_next  = out_err_reg;
    skid_hot_next = skid_hot_reg;
    skid_err_next = skid_err_reg;
    err_cnt_next  = err_cnt_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          out_hot_next = enc_hot;
          out_err_next = enc_err;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          out_hot_next = enc_hot;
          out_err_next = enc_err;
        end else if (accept) begin
          skid_hot_next = enc_hot;
          skid_err_next = enc_err;
          state_next    = FULL;
        end else if (transfer) begin
          // Clear the head so outputs read zero while nothing is valid.
          out_hot_next = '0;
          out_err_next = 1'b0;
          state_next   = EMPTY;
        end
      end
      FULL: begin
        if (transfer) begin
          out_hot_next = skid_hot_reg;
          out_err_next = skid_err_reg;
          state_next   = ONE;
        end
      end
      default: begin
        out_hot_next = '0;
        out_err_next = 1'b0;
        state_next   = EMPTY;
      end
    endcase

    if (clear_errors) begin
      err_cnt_next = 8'd0;
    end else if (accept && enc_err && (err_cnt_reg != 8'hFF)) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end

    in_ready_next = (state_next != FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= EMPTY;
      out_hot_reg  <= '0;
      out_err_reg  <= 1'b0;
      skid_hot_reg <= '0;
      skid_err_reg <= 1'b0;
      in_ready_reg <= 1'b0;
      err_cnt_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      out_hot_reg  <= out_hot_next;
      out_err_reg  <= out_err_next;
      skid_hot_reg <= skid_hot_next;
      skid_err_reg <= skid_err_next;
      in_ready_reg <= in_ready_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

endmodule
